// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : groups the hazard controller's pipeline-status inputs and control outputs.
// Latency : none, signal bundle only.
// Backpr. : none; the master modport drives pipeline status and the slave drives stall/flush controls.
interface pipe_hazard_ctrl_if #(
  parameter int DATA_LEN = 32,
  parameter int WAIT_W   = 8
);
  logic [DATA_LEN-1:0] ifid_inst_i;
  logic [DATA_LEN-1:0] idex_inst_i;
  logic                idex_memread_i;
  logic                branch_taken_i;
  logic                dmem_req_i;
  logic                dmem_ack_i;
  logic                pc_stall_o;
  logic                ifid_stall_o;
  logic                ifid_flush_o;
  logic                idex_stall_o;
  logic                idex_bubble_o;
  logic                exmem_stall_o;
  logic [1:0]          state_o;
  logic [WAIT_W-1:0]   wait_cnt_o;
  logic                timeout_o;
  logic [31:0]         stall_cycles_o;

  // Pipeline side: supplies instruction and memory status, consumes controls.
  modport master (
    output ifid_inst_i, idex_inst_i, idex_memread_i, branch_taken_i,
           dmem_req_i, dmem_ack_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
           idex_bubble_o, exmem_stall_o, state_o, wait_cnt_o, timeout_o,
           stall_cycles_o
  );

  // Controller side.
  modport slave (
    input  ifid_inst_i, idex_inst_i, idex_memread_i, branch_taken_i,
           dmem_req_i, dmem_ack_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
           idex_bubble_o, exmem_stall_o, state_o, wait_cnt_o, timeout_o,
           stall_cycles_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline sequencer deciding hold / bubble / flush for PC, IF/ID, ID/EX, EX/MEM.
// Latency : controls are combinational from state + inputs; state, wait counter, perf counter update on clk_i.
// Backpr. : an outstanding data-memory access freezes the whole pipe until ack; after MAX_WAIT cycles it locks in ERR.
// Ports   : clk_i/rst_i (async active-low); bus (slave modport) carries ID/EX instructions,
//           load flag, branch-taken, dmem req/ack in, and stall/flush/bubble controls plus debug/perf out.
module pipe_hazard_ctrl #(
  parameter int DATA_LEN = 32,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [31:0]       r_stall_cycles;

  logic [1:0]        w_next_state;
  logic [WAIT_W-1:0] w_next_cnt;
  logic              w_next_to;
  logic              w_eval_id;
  logic              w_pc_stall;
  logic              w_ifid_stall;
  logic              w_ifid_flush;
  logic              w_idex_stall;
  logic              w_idex_bubble;
  logic              w_exmem_stall;

  logic [4:0] w_ex_rd;
  logic [4:0] w_id_rs1;
  logic [4:0] w_id_rs2;
  logic       w_load_use;
  logic       w_mem_freeze;
  logic       w_unused_bits;

  assign w_ex_rd  = bus.idex_inst_i[11:7];
  assign w_id_rs1 = bus.ifid_inst_i[19:15];
  assign w_id_rs2 = bus.ifid_inst_i[24:20];
  // Only the register fields matter here; the rest of each word is decoded elsewhere.
  assign w_unused_bits = ^{bus.idex_inst_i[DATA_LEN-1:12], bus.idex_inst_i[6:0],
                           bus.ifid_inst_i[DATA_LEN-1:25], bus.ifid_inst_i[14:0]};

  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign w_load_use = bus.idex_memread_i && (w_ex_rd != 5'd0) &&
                      ((w_ex_rd == w_id_rs1) || (w_ex_rd == w_id_rs2));
  // req with ack in the same cycle is a zero-wait access, not a freeze.
  assign w_mem_freeze = bus.dmem_req_i && !bus.dmem_ack_i;

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_wait_cnt;
    w_next_to     = r_timeout;
    w_eval_id     = 1'b0;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_stall = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_mem_freeze) begin
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
          w_next_state = ST_WAIT;
          w_next_cnt   = WAIT_W'(1);
        end else begin
          w_eval_id = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.dmem_ack_i) begin
          // Data arrives: the pipe advances this cycle and ID hazards apply normally.
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
          w_eval_id    = 1'b1;
        end else begin
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
          if (r_wait_cnt >= WAIT_W'(MAX_WAIT)) begin
            // Counter holds at MAX_WAIT so the debug value shows where it gave up.
            w_next_state = ST_ERR;
            w_next_to    = 1'b1;
          end else begin
            w_next_cnt = r_wait_cnt + 1'b1;
          end
        end
      end
      ST_ERR: begin
        {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Load-use wins over branch: the branch is dropped and re-resolved next cycle
    // once the loaded operand is available, so flush and bubble never coincide.
    if (w_eval_id) begin
      if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_bubble = 1'b1;
      end else if (bus.branch_taken_i) begin
        w_ifid_flush = 1'b1;
      end
    end

    // Controls must be quiet for the whole time reset is held, not just after the edge.
    if (!rst_i) begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_stall  = 1'b0;
      w_idex_bubble = 1'b0;
      w_exmem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_next_state;
      r_wait_cnt     <= w_next_cnt;
      r_timeout      <= w_next_to;
      r_stall_cycles <= r_stall_cycles + {31'd0, w_pc_stall};
    end
  end

  assign bus.pc_stall_o     = w_pc_stall;
  assign bus.ifid_stall_o   = w_ifid_stall;
  assign bus.ifid_flush_o   = w_ifid_flush;
  assign bus.idex_stall_o   = w_idex_stall;
  assign bus.idex_bubble_o  = w_idex_bubble;
  assign bus.exmem_stall_o  = w_exmem_stall;
  assign bus.state_o        = r_state;
  assign bus.wait_cnt_o     = r_wait_cnt;
  assign bus.timeout_o      = r_timeout;
  assign bus.stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : directed, table-driven check of pipe_hazard_ctrl hazard decisions and wait/timeout sequencing.
// Latency : inputs driven 1 ns after rising edge, outputs sampled on the falling edge.
// Backpr. : n/a (bench).
module tb_pipe_hazard_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if #(.DATA_LEN(32), .WAIT_W(8)) u_if ();

  pipe_hazard_ctrl #(.DATA_LEN(32), .WAIT_W(8), .MAX_WAIT(200)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_stalls = 0;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall}
  typedef struct {
    logic        memread;
    logic [31:0] ex;
    logic [31:0] id;
    logic        br;
    logic        req;
    logic        ack;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [5:0] outs();
    return {u_if.pc_stall_o, u_if.ifid_stall_o, u_if.ifid_flush_o,
            u_if.idex_stall_o, u_if.idex_bubble_o, u_if.exmem_stall_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic memread, input logic [31:0] ex, input logic [31:0] id,
                       input logic br, input logic req, input logic ack);
    u_if.idex_memread_i = memread;
    u_if.idex_inst_i    = ex;
    u_if.ifid_inst_i    = id;
    u_if.branch_taken_i = br;
    u_if.dmem_req_i     = req;
    u_if.dmem_ack_i     = ack;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    vecs[0]  = '{1'b1, mk(5, 0, 0),   mk(6, 5, 1),   1'b0, 1'b0, 1'b0, 6'b110010}; // rs1 load-use
    vecs[1]  = '{1'b1, mk(0, 0, 0),   mk(6, 0, 0),   1'b0, 1'b0, 1'b0, 6'b000000}; // rd=x0 never hazards
    vecs[2]  = '{1'b1, mk(5, 0, 0),   mk(6, 2, 5),   1'b0, 1'b0, 1'b0, 6'b110010}; // rs2 load-use
    vecs[3]  = '{1'b0, mk(5, 0, 0),   mk(6, 5, 5),   1'b0, 1'b0, 1'b0, 6'b000000}; // not a load
    vecs[4]  = '{1'b1, mk(7, 0, 0),   mk(6, 1, 2),   1'b0, 1'b0, 1'b0, 6'b000000}; // no overlap
    vecs[5]  = '{1'b1, mk(31, 0, 0),  mk(1, 31, 0),  1'b0, 1'b0, 1'b0, 6'b110010}; // x31 boundary
    vecs[6]  = '{1'b1, mk(5, 0, 0),   mk(6, 5, 1),   1'b1, 1'b0, 1'b0, 6'b110010}; // branch suppressed
    vecs[7]  = '{1'b0, mk(5, 0, 0),   mk(6, 5, 1),   1'b1, 1'b0, 1'b0, 6'b001000}; // branch re-evaluated
    vecs[8]  = '{1'b0, mk(0, 0, 0),   mk(0, 0, 0),   1'b0, 1'b1, 1'b1, 6'b000000}; // zero-wait access
    vecs[9]  = '{1'b1, mk(9, 0, 0),   mk(3, 4, 9),   1'b0, 1'b1, 1'b1, 6'b110010}; // zero-wait + load-use
    vecs[10] = '{1'b0, mk(0, 0, 0),   mk(0, 0, 0),   1'b0, 1'b0, 1'b0, 6'b000000};

    // Reset: outputs quiet even with a load-use pattern on the inputs.
    drive(1'b1, mk(5, 0, 0), mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
    #12;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_state", 32'(u_if.state_o), 32'd0);
    chk("rst_wait_cnt", 32'(u_if.wait_cnt_o), 32'd0);
    chk("rst_timeout", 32'(u_if.timeout_o), 32'd0);
    chk("rst_stall_cycles", u_if.stall_cycles_o, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Single load-use bubble, then clean cycle.
    drive(1'b1, mk(5, 0, 0), mk(6, 5, 1), 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("lu_outs", 32'(outs()), 32'b110010);
    exp_stalls++;
    adv();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("lu_after_outs", 32'(outs()), 32'd0);
    chk("lu_stall_cycles", u_if.stall_cycles_o, 32'd1);
    adv();

    // Table of single-cycle RUN decisions.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].memread, vecs[i].ex, vecs[i].id, vecs[i].br, vecs[i].req, vecs[i].ack);
      @(negedge clk_i);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(u_if.state_o), 32'd0);
      if (vecs[i].exp[5]) exp_stalls++;
      adv();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("table_stall_cycles", u_if.stall_cycles_o, 32'(exp_stalls));
    adv();

    // Four-cycle memory wait, with a branch arriving during the freeze.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'd0, 32'd0, (k == 2), 1'b1, 1'b0);
      @(negedge clk_i);
      chk($sformatf("wait%0d_outs", k), 32'(outs()), 32'b110101);
      chk($sformatf("wait%0d_cnt", k), 32'(u_if.wait_cnt_o), 32'(k));
      chk($sformatf("wait%0d_state", k), 32'(u_if.state_o), (k == 0) ? 32'd0 : 32'd1);
      exp_stalls++;
      adv();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("ack_outs", 32'(outs()), 32'd0);
    chk("ack_cnt", 32'(u_if.wait_cnt_o), 32'd4);
    chk("ack_state", 32'(u_if.state_o), 32'd1);
    adv();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("post_ack_state", 32'(u_if.state_o), 32'd0);
    chk("post_ack_cnt", 32'(u_if.wait_cnt_o), 32'd0);
    chk("post_ack_stall_cycles", u_if.stall_cycles_o, 32'(exp_stalls));
    adv();

    // Timeout: one freeze edge + 199 counting edges + one edge into ERR.
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    edges = 0;
    while (u_if.state_o != 2'd2 && edges < 400) begin
      adv();
      edges++;
      exp_stalls++;
    end
    chk("to_edges", 32'(edges), 32'd201);
    chk("to_cnt", 32'(u_if.wait_cnt_o), 32'd200);
    chk("to_timeout", 32'(u_if.timeout_o), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("err_ack_outs", 32'(outs()), 32'b110101);
    exp_stalls++;
    adv();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("err_sticky_state", 32'(u_if.state_o), 32'd2);
    chk("err_sticky_timeout", 32'(u_if.timeout_o), 32'd1);
    chk("err_stall_cycles", u_if.stall_cycles_o, 32'(exp_stalls));
    #1 rst_i = 1'b0;
    #1;
    chk("err_rst_state", 32'(u_if.state_o), 32'd0);
    chk("err_rst_timeout", 32'(u_if.timeout_o), 32'd0);
    chk("err_rst_outs", 32'(outs()), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    exp_stalls = 0;

    // Asynchronous reset in the middle of a wait.
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    adv();
    adv();
    chk("mid_pre_state", 32'(u_if.state_o), 32'd1);
    chk("mid_pre_cnt", 32'(u_if.wait_cnt_o), 32'd2);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'd0);
    chk("mid_rst_cnt", 32'(u_if.wait_cnt_o), 32'd0);
    chk("mid_rst_stall_cycles", u_if.stall_cycles_o, 32'd0);
    chk("mid_rst_state", 32'(u_if.state_o), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_release_state", 32'(u_if.state_o), 32'd0);
    chk("mid_release_outs", 32'(outs()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
